// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: picks moles from an internal LFSR, times each mole
// and the whole game, and tracks score, misses and the best score since reset.
module whack_game_core #(
   parameter int          NUM_MOLES  = 8,
   parameter int          SCORE_W    = 8,
   parameter int          GAME_TICKS = 15000000,
   parameter int          MOLE_TICKS = 1500000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         IDX_W      = $clog2(NUM_MOLES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] btn,
   output logic [NUM_MOLES-1:0] mole_onehot,
   output logic [IDX_W-1:0]     mole_idx,
   output logic [SCORE_W-1:0]   score,
   output logic [SCORE_W-1:0]   miss_cnt,
   output logic [SCORE_W-1:0]   high_score,
   output logic                 playing,
   output logic                 game_over,
   output logic                 new_high
);

   localparam int GT_W = $clog2(GAME_TICKS + 1);
   localparam int MT_W = $clog2(MOLE_TICKS);
   localparam logic [GT_W-1:0]      GT_LAST  = GT_W'(GAME_TICKS - 1);
   localparam logic [MT_W-1:0]      MT_LAST  = MT_W'(MOLE_TICKS - 1);
   localparam logic [IDX_W:0]       N_WIDE   = (IDX_W + 1)'(NUM_MOLES);
   localparam logic [NUM_MOLES-1:0] ONE_MOLE = NUM_MOLES'(1);

   typedef enum logic [1:0] {IDLE, SPAWN, UP, OVER} state_t;

   state_t               state, state_nx;
   logic [15:0]          lfsr;
   logic                 lfsr_fb;
   logic                 start_q;
   logic                 start_edge;
   logic [NUM_MOLES-1:0] lockout, lockout_nx;
   logic [NUM_MOLES-1:0] eff;
   logic [GT_W-1:0]      game_timer, game_timer_nx;
   logic [MT_W-1:0]      mole_timer, mole_timer_nx;
   logic [SCORE_W-1:0]   score_nx, miss_nx, high_nx;
   logic [IDX_W-1:0]     idx_nx;
   logic [IDX_W-1:0]     cand_raw, cand_mod, cand_inc, cand;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == '1) ? v : v + SCORE_W'(1);
   endfunction

   // Mole candidate: fold the LFSR low bits into range, then step past a repeat.
   always_comb begin
      lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      start_edge = start & ~start_q;
      eff        = btn & ~lockout;
      cand_raw   = lfsr[IDX_W-1:0];
      cand_mod   = ({1'b0, cand_raw} >= N_WIDE) ? cand_raw - IDX_W'(NUM_MOLES) : cand_raw;
      cand_inc   = (({1'b0, cand_mod} + (IDX_W + 1)'(1)) == N_WIDE) ? '0 : cand_mod + IDX_W'(1);
      cand       = (cand_mod == mole_idx) ? cand_inc : cand_mod;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         start_q    <= 1'b0;
         lockout    <= '0;
         game_timer <= '0;
         mole_timer <= '0;
         score      <= '0;
         miss_cnt   <= '0;
         high_score <= '0;
         mole_idx   <= '0;
      end else begin
         state      <= state_nx;
         lfsr       <= {lfsr[14:0], lfsr_fb};
         start_q    <= start;
         lockout    <= lockout_nx;
         game_timer <= game_timer_nx;
         mole_timer <= mole_timer_nx;
         score      <= score_nx;
         miss_cnt   <= miss_nx;
         high_score <= high_nx;
         mole_idx   <= idx_nx;
      end
   end

   // A held button stays locked until it is seen released, so one press counts once.
   always_comb begin
      state_nx      = state;
      lockout_nx    = lockout & btn;
      game_timer_nx = game_timer;
      mole_timer_nx = mole_timer;
      score_nx      = score;
      miss_nx       = miss_cnt;
      high_nx       = high_score;
      idx_nx        = mole_idx;
      new_high      = 1'b0;
      mole_onehot   = '0;
      playing       = 1'b0;
      game_over     = 1'b0;

      case (state)
         IDLE, OVER: begin
            if (state == OVER) begin
               game_over = 1'b1;
               if (score > high_score) begin
                  high_nx  = score;
                  new_high = 1'b1;
               end
            end
            if (start_edge) begin
               state_nx      = SPAWN;
               score_nx      = '0;
               miss_nx       = '0;
               game_timer_nx = '0;
               mole_timer_nx = '0;
            end
         end
         SPAWN: begin
            playing       = 1'b1;
            idx_nx        = cand;
            lockout_nx    = btn;
            mole_timer_nx = '0;
            game_timer_nx = game_timer + GT_W'(1);
            state_nx      = UP;
         end
         UP: begin
            playing       = 1'b1;
            mole_onehot   = ONE_MOLE << mole_idx;
            game_timer_nx = game_timer + GT_W'(1);
            mole_timer_nx = mole_timer + MT_W'(1);
            if (game_timer >= GT_LAST) begin
               state_nx = OVER;
            end else if (eff[mole_idx]) begin
               score_nx = sat_inc(score);
               state_nx = SPAWN;
            end else if (mole_timer == MT_LAST) begin
               miss_nx  = sat_inc(miss_cnt);
               state_nx = SPAWN;
            end else if (|eff) begin
               miss_nx    = sat_inc(miss_cnt);
               lockout_nx = (lockout & btn) | eff;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
